// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the fetch front end     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_pkg;

    localparam int XLEN = 32;

    typedef logic [31:0] inst_t;

    localparam inst_t NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        inst_t           inst;
        logic            reserved;
        logic            filled;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_buf : in-order reservation ring of fetched instructions      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_flush,
    input  logic            i_reserve,
    input  logic [XLEN-1:0] i_reserve_pc,
    input  logic            i_fill,
    input  inst_t           i_fill_inst,
    input  logic            i_pop,
    output logic            o_head_vld,
    output inst_t           o_head_inst,
    output logic [XLEN-1:0] o_head_pc,
    output logic [CW-1:0]   o_used
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  r_slot [DEPTH];
    fetch_entry_t  w_head;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_fill_ptr;
    logic [CW-1:0] r_used;

    // Reserve, fill and pop always target distinct slots, so their updates never collide.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slot[i].reserved <= 1'b0;
                r_slot[i].filled   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_pop && r_rd_ptr == PW'(i)) begin
                    r_slot[i].reserved <= 1'b0;
                    r_slot[i].filled   <= 1'b0;
                end
                if (i_reserve && r_wr_ptr == PW'(i)) begin
                    r_slot[i].pc       <= i_reserve_pc;
                    r_slot[i].reserved <= 1'b1;
                    r_slot[i].filled   <= 1'b0;
                end
                if (i_fill && r_fill_ptr == PW'(i)) begin
                    r_slot[i].inst   <= i_fill_inst;
                    r_slot[i].filled <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill_ptr <= '0;
            r_used     <= '0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill_ptr <= '0;
            r_used     <= '0;
        end else begin
            if (i_reserve) r_wr_ptr   <= r_wr_ptr + PW'(1);
            if (i_pop)     r_rd_ptr   <= r_rd_ptr + PW'(1);
            if (i_fill)    r_fill_ptr <= r_fill_ptr + PW'(1);
            r_used <= r_used + CW'(i_reserve) - CW'(i_pop);
        end
    end

    assign w_head      = r_slot[r_rd_ptr];
    assign o_head_vld  = w_head.reserved && w_head.filled;
    assign o_head_inst = w_head.inst;
    assign o_head_pc   = w_head.pc;
    assign o_used      = r_used;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : decoupled instruction fetch with redirect flushing    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_imem_req_vld,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_req_rdy,
    input  logic            i_imem_rsp_vld,
    input  logic [31:0]     i_imem_rsp_data,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_inst_vld,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    input  logic            i_inst_rdy,
    output logic [XLEN-1:0] o_pc_debug,
    output logic            o_insn_vld
);
    import fetch_pkg::*;

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_kill_cnt;
    logic [XLEN-1:0] r_pc_debug;
    logic            r_insn_vld;

    logic [CW-1:0]   w_used;
    logic [CW:0]     w_credit_used;
    logic            w_req_vld;
    logic            w_req_fire;
    logic            w_rsp_kill;
    logic            w_rsp_redir_drop;
    logic            w_fill;
    logic            w_pop;
    logic            w_head_vld;
    logic            w_unused_pc_lsb;

    // Stale responses still in flight hold credit until they drain.
    assign w_credit_used = {1'b0, w_used} + {1'b0, r_kill_cnt};
    assign w_req_vld     = i_reset && !i_redirect && (w_credit_used < C_DEPTH);
    assign w_req_fire    = w_req_vld && i_imem_req_rdy;

    assign w_rsp_kill       = i_imem_rsp_vld && (r_kill_cnt != '0);
    assign w_fill           = i_imem_rsp_vld && !i_redirect && (r_kill_cnt == '0) && (r_outstanding != '0);
    assign w_rsp_redir_drop = i_imem_rsp_vld && ((r_kill_cnt + r_outstanding) != '0);
    assign w_pop            = w_head_vld && i_inst_rdy;
    assign w_unused_pc_lsb  = ^i_redirect_pc[1:0];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_kill_cnt    <= '0;
            r_pc_debug    <= RESET_PC;
            r_insn_vld    <= 1'b0;
        end else begin
            r_insn_vld <= w_pop;
            if (w_pop) r_pc_debug <= o_inst_pc;
            if (i_redirect) begin
                r_fetch_pc    <= {i_redirect_pc[XLEN-1:2], 2'b00};
                r_kill_cnt    <= r_kill_cnt + r_outstanding - CW'(w_rsp_redir_drop);
                r_outstanding <= '0;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_rsp_kill) r_kill_cnt <= r_kill_cnt - CW'(1);
                r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_fill);
            end
        end
    end

    fetch_buf #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_buf (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_flush      (i_redirect),
        .i_reserve    (w_req_fire),
        .i_reserve_pc (r_fetch_pc),
        .i_fill       (w_fill),
        .i_fill_inst  (i_imem_rsp_data),
        .i_pop        (w_pop),
        .o_head_vld   (w_head_vld),
        .o_head_inst  (o_inst),
        .o_head_pc    (o_inst_pc),
        .o_used       (w_used)
    );

    assign o_imem_req_vld  = w_req_vld;
    assign o_imem_req_addr = r_fetch_pc;
    assign o_inst_vld      = w_head_vld;
    assign o_pc_debug      = r_pc_debug;
    assign o_insn_vld      = r_insn_vld;

    a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (!i_reset)
        !(i_imem_rsp_vld && r_outstanding == '0 && r_kill_cnt == '0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit : fetch_unit against an in-order imem and PC model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        o_imem_req_vld;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_req_rdy = 1'b0;
    logic        i_imem_rsp_vld = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_inst_vld;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_rdy = 1'b0;
    logic [31:0] o_pc_debug;
    logic        o_insn_vld;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .o_imem_req_vld  (o_imem_req_vld),
        .o_imem_req_addr (o_imem_req_addr),
        .i_imem_req_rdy  (i_imem_req_rdy),
        .i_imem_rsp_vld  (i_imem_rsp_vld),
        .i_imem_rsp_data (i_imem_rsp_data),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .o_inst_vld      (o_inst_vld),
        .o_inst          (o_inst),
        .o_inst_pc       (o_inst_pc),
        .i_inst_rdy      (i_inst_rdy),
        .o_pc_debug      (o_pc_debug),
        .o_insn_vld      (o_insn_vld)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } req_t;

    typedef struct {
        int          lat;
        int          irdy;
        int          pre;
        logic [31:0] rpc;
        logic [31:0] exp0;
        logic [31:0] exp1;
        bit          dbg_chk;
        logic [31:0] dbg;
    } rvec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: imem in-flight queue tagged by redirect epoch, plus
    // the program-order list of PCs decode is owed since the last redirect.
    req_t        imq[$];
    logic [31:0] liveq[$];
    int          n_filled;
    int          epoch;
    int          cyc;
    int          last_due;
    logic [31:0] exp_addr;
    logic [31:0] exp_dbg;

    int          p_rdy, p_irdy, p_redir, lat_lo, lat_hi;
    bit          force_redir;
    logic [31:0] force_pc;

    logic [31:0] dec_pc_log[$];
    int          dec_cyc_log[$];
    logic [31:0] req_log[$];
    int          req_cyc_log[$];

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req_vld"},  {31'b0, o_imem_req_vld}, 32'h0);
        chk({tag, "_inst_vld"}, {31'b0, o_inst_vld},     32'h0);
        chk({tag, "_inst"},     o_inst,                  32'h0);
        chk({tag, "_inst_pc"},  o_inst_pc,               32'h0);
        chk({tag, "_pc_debug"}, o_pc_debug,              RESET_PC);
        chk({tag, "_insn_vld"}, {31'b0, o_insn_vld},     32'h0);
    endtask

    task automatic do_reset(int n);
        i_reset = 1'b0;
        i_redirect = 1'b0; i_redirect_pc = '0;
        i_imem_rsp_vld = 1'b0; i_imem_rsp_data = '0;
        i_imem_req_rdy = 1'b0; i_inst_rdy = 1'b0;
        #1;
        chk_reset_outputs("rst_assert");
        repeat (n) @(posedge i_clk);
        #1;
        chk_reset_outputs("rst_hold");
        imq.delete(); liveq.delete();
        dec_pc_log.delete(); dec_cyc_log.delete();
        req_log.delete(); req_cyc_log.delete();
        n_filled = 0; epoch = 0; cyc = 0; last_due = 0;
        exp_addr = RESET_PC; exp_dbg = RESET_PC;
        force_redir = 0;
        i_reset = 1'b1;
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the
    // model, advance the model across the edge, then check registered outputs.
    task automatic step();
        req_t        r;
        bit          rsp_now, redir, exp_req, exp_ivld, m_pop;
        int          stale, lat, due;
        logic [31:0] pop_pc;
        r = '{addr: '0, due: 0, ep: 0};
        rsp_now = 0;
        i_imem_rsp_vld = 1'b0;
        i_imem_rsp_data = '0;
        if (imq.size() > 0 && imq[0].due <= cyc) begin
            r = imq.pop_front();
            rsp_now = 1;
            i_imem_rsp_vld = 1'b1;
            i_imem_rsp_data = mem_word(r.addr);
        end
        redir = force_redir || ($urandom_range(99) < p_redir);
        i_redirect = redir;
        i_redirect_pc = force_redir ? force_pc : $urandom();
        force_redir = 0;
        i_imem_req_rdy = ($urandom_range(99) < p_rdy);
        i_inst_rdy = ($urandom_range(99) < p_irdy);
        #1;

        stale = 0;
        foreach (imq[i]) if (imq[i].ep != epoch) stale++;
        if (rsp_now && r.ep != epoch) stale++;
        exp_req = !redir && (liveq.size() + stale < DEPTH);
        chk("req_vld", {31'b0, o_imem_req_vld}, {31'b0, exp_req});
        if (exp_req) chk("req_addr", o_imem_req_addr, exp_addr);
        exp_ivld = (n_filled > 0);
        chk("inst_vld", {31'b0, o_inst_vld}, {31'b0, exp_ivld});
        m_pop = exp_ivld && i_inst_rdy;
        if (m_pop) begin
            chk("inst_pc", o_inst_pc, liveq[0]);
            chk("inst", o_inst, mem_word(liveq[0]));
        end
        if (o_inst_vld && i_inst_rdy) begin
            dec_pc_log.push_back(o_inst_pc);
            dec_cyc_log.push_back(cyc);
        end
        if (o_imem_req_vld && i_imem_req_rdy) begin
            req_log.push_back(o_imem_req_addr);
            req_cyc_log.push_back(cyc);
        end

        pop_pc = '0;
        if (m_pop) begin
            pop_pc = liveq.pop_front();
            n_filled--;
        end
        if (rsp_now && !redir && r.ep == epoch) n_filled++;
        if (exp_req && i_imem_req_rdy) begin
            lat = $urandom_range(lat_hi, lat_lo);
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            imq.push_back('{addr: exp_addr, due: due, ep: epoch});
            liveq.push_back(exp_addr);
            exp_addr += 32'd4;
        end
        if (redir) begin
            liveq.delete();
            n_filled = 0;
            epoch++;
            exp_addr = {i_redirect_pc[31:2], 2'b00};
        end

        @(posedge i_clk);
        cyc++;
        #1;
        chk("insn_vld", {31'b0, o_insn_vld}, {31'b0, m_pop});
        if (m_pop) exp_dbg = pop_pc;
        chk("pc_debug", o_pc_debug, exp_dbg);
    endtask

    task automatic knobs(int rdy, int irdy, int redir, int lo, int hi);
        p_rdy = rdy; p_irdy = irdy; p_redir = redir; lat_lo = lo; lat_hi = hi;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rvec_t vecs[5];
        int    mark;

        vecs[0] = '{lat: 4, irdy: 100, pre: 3, rpc: 32'h0000_0103, exp0: 32'h0000_0100, exp1: 32'h0000_0104, dbg_chk: 1, dbg: 32'h0};
        vecs[1] = '{lat: 1, irdy: 100, pre: 4, rpc: 32'h0000_0200, exp0: 32'h0000_0200, exp1: 32'h0000_0204, dbg_chk: 1, dbg: 32'h8};
        vecs[2] = '{lat: 2, irdy: 100, pre: 5, rpc: 32'hFFFF_FFFC, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000, dbg_chk: 0, dbg: 32'h0};
        vecs[3] = '{lat: 3, irdy: 0,   pre: 4, rpc: 32'h0000_002A, exp0: 32'h0000_0028, exp1: 32'h0000_002C, dbg_chk: 1, dbg: 32'h0};
        vecs[4] = '{lat: 1, irdy: 50,  pre: 6, rpc: 32'h7FFF_FFFE, exp0: 32'h7FFF_FFFC, exp1: 32'h8000_0000, dbg_chk: 0, dbg: 32'h0};

        knobs(100, 100, 0, 1, 1);
        do_reset(2);

        // Reset in the middle of traffic with three requests in flight.
        knobs(100, 0, 0, 4, 4);
        repeat (3) step();
        chk("t1_inflight", imq.size(), 3);
        do_reset(2);
        knobs(100, 100, 0, 1, 1);
        repeat (4) step();
        chk("t1_req_cnt", req_log.size(), 4);
        if (req_log.size() > 0) chk("t1_first_addr", req_log[0], RESET_PC);

        // Streaming at latency 1: decode sees 0,4,8,C on consecutive cycles.
        do_reset(1);
        knobs(100, 100, 0, 1, 1);
        repeat (6) step();
        chk("t2_dec_cnt", dec_pc_log.size(), 4);
        if (dec_pc_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_dec_pc", dec_pc_log[i], 32'(4 * i));
                if (i > 0) chk("t2_dec_cyc", dec_cyc_log[i], dec_cyc_log[i-1] + 1);
            end
        end

        // Decode stalled: exactly DEPTH requests, next one the cycle after a pop.
        do_reset(1);
        knobs(100, 0, 0, 1, 1);
        repeat (8) step();
        chk("t3_req_cnt", req_log.size(), 4);
        if (req_log.size() == 4) chk("t3_last_addr", req_log[3], 32'hC);
        p_irdy = 100;
        step();
        p_irdy = 0;
        repeat (3) step();
        chk("t3_req_cnt2", req_log.size(), 5);
        chk("t3_pop_cnt", dec_pc_log.size(), 1);
        if (req_log.size() == 5 && dec_cyc_log.size() == 1) begin
            chk("t3_next_addr", req_log[4], 32'h10);
            chk("t3_next_cyc", req_cyc_log[4], dec_cyc_log[0] + 1);
        end

        // Redirect vectors.
        for (int v = 0; v < 5; v++) begin
            do_reset(1);
            knobs(100, vecs[v].irdy, 0, vecs[v].lat, vecs[v].lat);
            repeat (vecs[v].pre) step();
            force_redir = 1;
            force_pc = vecs[v].rpc;
            step();
            if (vecs[v].dbg_chk) chk("redir_dbg", o_pc_debug, vecs[v].dbg);
            p_irdy = 100;
            mark = dec_pc_log.size();
            for (int k = 0; k < 100 && dec_pc_log.size() < mark + 2; k++) step();
            if (dec_pc_log.size() >= mark + 2) begin
                chk("redir_pc0", dec_pc_log[mark], vecs[v].exp0);
                chk("redir_pc1", dec_pc_log[mark + 1], vecs[v].exp1);
            end else begin
                chk("redir_timeout", dec_pc_log.size(), mark + 2);
            end
        end

        // Randomized traffic against the reference model.
        do_reset(1);
        for (int seg = 0; seg < 6; seg++) begin
            knobs($urandom_range(100, 30), $urandom_range(100, 20),
                  $urandom_range(8, 0), 1, $urandom_range(6, 1));
            if (seg == 3) do_reset(2);
            repeat (500) step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
